// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin arbiter sharing one byte-wide SPI master between two requesters
// Optional feature macro: SPI_ARB_TIMEOUT_EN (abort a stalled burst after TIMEOUT idle cycles)
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/data/last   per-requester byte offer (byte k on req_data_i[8k+7:8k])
//   req_ready_o             per-requester byte accepted pulse
//   rsp_valid_o, rsp_data_o received byte pulse (per requester) and shared data
//   grant_o, busy_o, err_o  current/last owner, CS asserted, timeout abort pulse
//   cs_n_o                  active-low chip selects, one per requester
//   spi_*                   handshake with the SPI master
module spi_xfer_arbiter #(
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int TIMEOUT  = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_valid_i,
   input  logic [15:0] req_data_i,
   input  logic [1:0]  req_last_i,
   output logic [1:0]  req_ready_o,
   output logic [1:0]  rsp_valid_o,
   output logic [7:0]  rsp_data_o,
   output logic        grant_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [1:0]  cs_n_o,
   output logic [7:0]  spi_din_o,
   output logic        spi_start_o,
   input  logic [7:0]  spi_dout_i,
   input  logic        spi_done_tick_i,
   input  logic        spi_ready_i
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_HOLD} state_t;

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        grant_q, grant_d;
   logic        rr_q, rr_d;
   logic        last_q, last_d;
   logic        busy_q, busy_d;
   logic [1:0]  cs_n_q, cs_n_d;
   logic [7:0]  spi_din_q, spi_din_d;
   logic        spi_start_q, spi_start_d;
   logic [1:0]  req_ready_q, req_ready_d;
   logic [1:0]  rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        err_q, err_d;
   logic        winner;
   logic        own_valid;
   logic        own_last;
   logic [7:0]  own_data;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
   logic [31:0] to_cnt_q, to_cnt_d;
`endif

   // rr_q names the favoured requester; it only matters on a tie
   assign winner    = (&req_valid_i) ? rr_q : req_valid_i[1];
   assign own_valid = grant_q ? req_valid_i[1] : req_valid_i[0];
   assign own_last  = grant_q ? req_last_i[1] : req_last_i[0];
   assign own_data  = grant_q ? req_data_i[15:8] : req_data_i[7:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      last_d      = last_q;
      busy_d      = busy_q;
      cs_n_d      = cs_n_q;
      spi_din_d   = spi_din_q;
      spi_start_d = 1'b0;
      req_ready_d = 2'b00;
      rsp_valid_d = 2'b00;
      rsp_data_d  = rsp_data_q;
      err_d       = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req_valid_i) begin
               grant_d = winner;
               cs_n_d  = winner ? 2'b01 : 2'b10;
               busy_d  = 1'b1;
               cnt_d   = 8'd0;
               state_d = S_SETUP;
`ifdef SPI_ARB_TIMEOUT_EN
               to_cnt_d = 32'd0;
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_SEND;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_SEND: begin
            if (own_valid && spi_ready_i) begin
               spi_din_d   = own_data;
               spi_start_d = 1'b1;
               req_ready_d = grant_q ? 2'b10 : 2'b01;
               last_d      = own_last;
               state_d     = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
               to_cnt_d    = 32'd0;
            end else if (!own_valid) begin
               // owner went quiet mid-burst: give up after TIMEOUT idle cycles
               if (to_cnt_q == TO_LAST) begin
                  err_d   = 1'b1;
                  cnt_d   = 8'd0;
                  state_d = S_HOLD;
               end else begin
                  to_cnt_d = to_cnt_q + 32'd1;
               end
`endif
            end
         end
         S_WAIT: begin
            if (spi_done_tick_i) begin
               rsp_data_d  = spi_dout_i;
               rsp_valid_d = grant_q ? 2'b10 : 2'b01;
               cnt_d       = 8'd0;
               state_d     = last_q ? S_HOLD : S_SEND;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cs_n_d  = 2'b11;
               busy_d  = 1'b0;
               rr_d    = ~grant_q;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         grant_q     <= 1'b0;
         rr_q        <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         cs_n_q      <= 2'b11;
         spi_din_q   <= 8'd0;
         spi_start_q <= 1'b0;
         req_ready_q <= 2'b00;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= 8'd0;
         err_q       <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         to_cnt_q    <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         cs_n_q      <= cs_n_d;
         spi_din_q   <= spi_din_d;
         spi_start_q <= spi_start_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
`ifdef SPI_ARB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign grant_o     = grant_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;
   assign cs_n_o      = cs_n_q;
   assign spi_din_o   = spi_din_q;
   assign spi_start_o = spi_start_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - scoreboard bench for spi_xfer_arbiter
module tb_spi_xfer_arbiter;

   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int SPI_LAT  = 3;
   // CS low: setup cycles, one SEND cycle, start-to-done (SPI_LAT + 1), hold cycles
   localparam int LOW_1BYTE = CS_SETUP + 1 + (SPI_LAT + 1) + CS_HOLD;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [1:0]  req_valid_i = 2'b00;
   logic [15:0] req_data_i = 16'h0;
   logic [1:0]  req_last_i = 2'b00;
   logic [1:0]  req_ready_o;
   logic [1:0]  rsp_valid_o;
   logic [7:0]  rsp_data_o;
   logic        grant_o;
   logic        busy_o;
   logic        err_o;
   logic [1:0]  cs_n_o;
   logic [7:0]  spi_din_o;
   logic        spi_start_o;
   logic [7:0]  spi_dout_i = 8'h0;
   logic        spi_done_tick_i = 1'b0;
   logic        spi_ready_i = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int low0_cnt = 0;
   int rise_cnt = 0;
   int err_cnt = 0;
   int rise_before;
   logic no_start_win = 1'b0;
   logic [1:0] cs_prev = 2'b11;
   logic [8:0] exp_start[$];
   logic [9:0] exp_rsp[$];

   spi_xfer_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(10)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o), .cs_n_o(cs_n_o),
      .spi_din_o(spi_din_o), .spi_start_o(spi_start_o), .spi_dout_i(spi_dout_i),
      .spi_done_tick_i(spi_done_tick_i), .spi_ready_i(spi_ready_i)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // expected traffic: start carries {grant, tx byte}, response {rsp_valid mask, rx byte}
   task automatic expect_xfer(input logic k, input logic [7:0] b);
      exp_start.push_back({k, b});
      exp_rsp.push_back({(k ? 2'b10 : 2'b01), b ^ 8'h99});
   endtask

   task automatic send(input int k, input logic [7:0] b, input logic last);
      int n = 0;
      req_valid_i[k] = 1'b1;
      req_data_i[8*k +: 8] = b;
      req_last_i[k] = last;
      do begin
         @(negedge clk_i);
         n++;
      end while (!req_ready_o[k] && n < 200);
      chk("req_ready_seen", {31'd0, req_ready_o[k]}, 32'd1);
      req_valid_i[k] = 1'b0;
      req_last_i[k] = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_o || cs_n_o != 2'b11) && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("idle_reached", {31'd0, (n < 200)}, 32'd1);
   endtask

   task automatic queues_empty(input string tag);
      chk({tag, "_start_q"}, exp_start.size(), 0);
      chk({tag, "_rsp_q"}, exp_rsp.size(), 0);
   endtask

   // SPI master model: byte returns as tx ^ 0x99, SPI_LAT cycles after the start pulse
   initial begin
      logic [7:0] tx;
      forever begin
         @(negedge clk_i);
         if (spi_start_o) begin
            tx = spi_din_o;
            spi_ready_i = 1'b0;
            repeat (SPI_LAT) @(negedge clk_i);
            spi_dout_i = tx ^ 8'h99;
            spi_done_tick_i = 1'b1;
            @(negedge clk_i);
            spi_done_tick_i = 1'b0;
            spi_ready_i = 1'b1;
         end
      end
   end

   // scoreboard and protocol monitor
   initial begin
      logic [8:0] es;
      logic [9:0] er;
      forever begin
         @(negedge clk_i);
         if (spi_start_o) begin
            chk("start_expected", {31'd0, (exp_start.size() != 0)}, 32'd1);
            if (exp_start.size() != 0) begin
               es = exp_start.pop_front();
               chk("start_din", {24'd0, spi_din_o}, {24'd0, es[7:0]});
               chk("start_grant", {31'd0, grant_o}, {31'd0, es[8]});
            end
         end
         if (rsp_valid_o != 2'b00) begin
            chk("rsp_expected", {31'd0, (exp_rsp.size() != 0)}, 32'd1);
            if (exp_rsp.size() != 0) begin
               er = exp_rsp.pop_front();
               chk("rsp_valid", {30'd0, rsp_valid_o}, {30'd0, er[9:8]});
               chk("rsp_data", {24'd0, rsp_data_o}, {24'd0, er[7:0]});
            end
         end
         chk("cs_one_low", {31'd0, (cs_n_o != 2'b00)}, 32'd1);
         if (cs_n_o != cs_prev)
            chk("cs_high_gap", {31'd0, (cs_prev == 2'b11 || cs_n_o == 2'b11)}, 32'd1);
         if (no_start_win)
            chk("stall_no_start", {31'd0, spi_start_o}, 32'd0);
         if (cs_prev != 2'b11 && cs_n_o == 2'b11) rise_cnt++;
         if (cs_n_o == 2'b10) low0_cnt++;
         if (err_o) err_cnt++;
         cs_prev = cs_n_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk_i);
      chk("rst_cs_n", {30'd0, cs_n_o}, 32'h3);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_grant", {31'd0, grant_o}, 32'd0);
      chk("rst_pulses", {27'd0, spi_start_o, req_ready_o, rsp_valid_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_data", {16'd0, spi_din_o, rsp_data_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // single byte from requester 0
      expect_xfer(1'b0, 8'hA5);
      low0_cnt = 0;
      send(0, 8'hA5, 1'b1);
      wait_idle();
      chk("t1_cs_low_cycles", low0_cnt, LOW_1BYTE);
      chk("t1_cs_released", {30'd0, cs_n_o}, 32'h3);
      queues_empty("t1");

      // three-byte burst from requester 1, single CS window
      rise_before = rise_cnt;
      expect_xfer(1'b1, 8'h11);
      expect_xfer(1'b1, 8'h22);
      expect_xfer(1'b1, 8'h33);
      send(1, 8'h11, 1'b0);
      chk("t2_cs1_low", {30'd0, cs_n_o}, 32'h1);
      send(1, 8'h22, 1'b0);
      chk("t2_cs1_low", {30'd0, cs_n_o}, 32'h1);
      send(1, 8'h33, 1'b1);
      wait_idle();
      chk("t2_one_cs_rise", rise_cnt - rise_before, 1);
      queues_empty("t2");

      // tie from reset: grants alternate 0,1,0,1
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      expect_xfer(1'b0, 8'h61);
      expect_xfer(1'b1, 8'h71);
      expect_xfer(1'b0, 8'h62);
      expect_xfer(1'b1, 8'h72);
      fork
         begin send(0, 8'h61, 1'b1); send(0, 8'h62, 1'b1); end
         begin send(1, 8'h71, 1'b1); send(1, 8'h72, 1'b1); end
      join
      wait_idle();
      queues_empty("t3");

      // stall between burst bytes
      expect_xfer(1'b0, 8'h40);
      expect_xfer(1'b0, 8'h41);
      err_cnt = 0;
      send(0, 8'h40, 1'b0);
      @(negedge clk_i);
      no_start_win = 1'b1;
      repeat (19) @(negedge clk_i);
      no_start_win = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      chk("t4_err_pulses", err_cnt, 1);
      chk("t4_cs_released", {30'd0, cs_n_o}, 32'h3);
`else
      chk("t4_cs0_held", {30'd0, cs_n_o}, 32'h2);
      chk("t4_busy_held", {31'd0, busy_o}, 32'd1);
`endif
      send(0, 8'h41, 1'b1);
      wait_idle();
      queues_empty("t4");

      // reset during WAIT of the second burst byte
      expect_xfer(1'b0, 8'h51);
      exp_start.push_back({1'b0, 8'h52});
      send(0, 8'h51, 1'b0);
      send(0, 8'h52, 1'b0);
      #2 rst_i = 1'b1;
      #1;
      chk("t5_cs_async", {30'd0, cs_n_o}, 32'h3);
      chk("t5_busy", {31'd0, busy_o}, 32'd0);
      chk("t5_pulses", {27'd0, spi_start_o, req_ready_o, rsp_valid_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      expect_xfer(1'b0, 8'h5A);
      send(0, 8'h5A, 1'b1);
      wait_idle();
      queues_empty("t5");

      // spurious done ticks in IDLE and SETUP
      repeat (8) @(negedge clk_i);
      spi_dout_i = 8'hEE;
      spi_done_tick_i = 1'b1;
      @(negedge clk_i);
      spi_done_tick_i = 1'b0;
      chk("t6_idle_busy", {31'd0, busy_o}, 32'd0);
      chk("t6_idle_rsp", {30'd0, rsp_valid_o}, 32'd0);
      expect_xfer(1'b0, 8'h66);
      low0_cnt = 0;
      req_valid_i[0] = 1'b1;
      req_data_i[7:0] = 8'h66;
      req_last_i[0] = 1'b1;
      @(negedge clk_i);
      chk("t6_setup_busy", {31'd0, busy_o}, 32'd1);
      spi_done_tick_i = 1'b1;
      @(negedge clk_i);
      spi_done_tick_i = 1'b0;
      chk("t6_setup_rsp", {30'd0, rsp_valid_o}, 32'd0);
      send(0, 8'h66, 1'b1);
      wait_idle();
      chk("t6_cs_low_cycles", low0_cnt, LOW_1BYTE);
      queues_empty("t6");

`ifdef SPI_ARB_TIMEOUT_EN
      chk("err_total", err_cnt, 1);
`else
      chk("err_total", err_cnt, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Shares one byte-wide SPI master (din/start/dout/done_tick/ready handshake) between two requesters. Performs round-robin arbitration per transaction and drives one active-low chip select per requester. Holds the grant for a multi-byte burst until the requester marks its last byte. Sits between the SPI master and the two client blocks, with CS setup/hold timing in clock cycles.

Parameters:
CS_SETUP, 2, cycles CS low before first start pulse (legal 1..255)
CS_HOLD, 2, cycles CS stays low after last done tick (legal 1..255)
TIMEOUT, 1000, max idle cycles waiting for next burst byte (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  2  per requester: byte available
req_data_i  in  16  byte for requester k on [8k+7:8k]
req_last_i  in  2  per requester: byte is last of burst
req_ready_o  out  2  per requester: byte accepted (1-cycle pulse)
rsp_valid_o  out  2  per requester: received byte valid (1-cycle pulse)
rsp_data_o  out  8  received byte, shared, valid with rsp_valid_o
grant_o  out  1  index of current/last owner
busy_o  out  1  transaction in progress (CS asserted)
err_o  out  1  timeout abort pulse (0 when feature compiled out)
cs_n_o  out  2  active-low chip selects
spi_din_o  out  8  byte to SPI master
spi_start_o  out  1  start pulse to SPI master
spi_dout_i  in  8  byte from SPI master
spi_done_tick_i  in  1  SPI master byte complete
spi_ready_i  in  1  SPI master idle

Behaviour:
- Clock clk_i, reset rst_i: asynchronous, active-high. All outputs registered.
- Reset values: cs_n_o=2'b11, all other outputs 0. rr pointer favours requester 0. FSM=IDLE.
- FSM states: IDLE, SETUP, SEND, WAIT, HOLD.
- IDLE: if any req_valid_i, grant by round-robin: the requester not granted last wins a tie. Next cycle: grant_o=winner, cs_n_o[winner]=0, busy_o=1, enter SETUP. req_ready_o is not asserted in IDLE.
- SETUP: count CS_SETUP cycles, then SEND.
- SEND: when req_valid_i[g] && spi_ready_i, register the following in one cycle:
  - spi_din_o=req_data_i byte g
  - spi_start_o=1
  - req_ready_o[g]=1
  - latch req_last_i[g]
  - then enter WAIT.
- SEND stall: if req_valid_i[g]=0, stay in SEND with CS held low.
- WAIT: on spi_done_tick_i, register rsp_data_o=spi_dout_i and rsp_valid_o[g]=1 (one cycle). Then HOLD if the latched last=1, else SEND.
- HOLD: count CS_HOLD cycles, then release:
  - cs_n_o=2'b11, busy_o=0
  - rr pointer set so the other requester has priority
  - return to IDLE. The earliest new grant is 1 cycle later, giving a minimum CS-high gap of 1 cycle.
- Non-owner requests are ignored during a transaction; their req_ready_o stays 0.
- spi_done_tick_i outside WAIT: ignored.
- spi_start_o, req_ready_o and rsp_valid_o are always single-cycle pulses.
- At most one cs_n_o bit is low at any time.
- Reset mid-transaction: cs_n_o goes to 2'b11 asynchronously, FSM returns to IDLE, and the partial burst is dropped.

Optional Feature:
SPI_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in SEND while req_valid_i[g]=0. When it reaches TIMEOUT:
  - err_o pulses for 1 cycle
  - the FSM enters HOLD (normal CS_HOLD release)
  - the rr pointer advances.
- The counter clears on each accepted byte.
- Undefined: there is no counter, SEND waits indefinitely, and err_o is tied 0.

Test Plan:
1. Single byte: after reset, req0 sends 0xA5 with last=1; the SPI model returns 0x3C.
   - cs_n_o=2'b10 for CS_SETUP + transfer + CS_HOLD cycles.
   - One spi_start_o with spi_din_o=0xA5, then rsp_valid_o=2'b01 with rsp_data_o=0x3C.
   - busy_o then falls and cs_n_o=2'b11.
2. Burst: req1 sends 0x11, 0x22, 0x33 (last on 0x33).
   - cs_n_o[1] stays low across all three bytes, with three start pulses and three rsp_valid_o[1] pulses in order.
   - CS rises only after HOLD.
3. Tie and round-robin: both requesters valid with 1-byte transfers, continuously, from reset.
   - Grants go 0, 1, 0, 1.
   - Each transaction is separated by at least 1 cycle with cs_n_o=2'b11.
4. Stall: req0 burst with req_valid_i[0] dropped 20 cycles between bytes.
   - cs_n_o[0] stays low and no start pulse occurs during the gap.
   - With SPI_ARB_TIMEOUT_EN and TIMEOUT=10, err_o pulses at cycle 10 and CS releases after CS_HOLD.
5. Reset mid-burst: assert rst_i during WAIT of byte 2.
   - cs_n_o=2'b11 with no clock edge needed.
   - All pulses are 0; after release, a new req0 transfer completes normally.
6. Spurious done: pulse spi_done_tick_i while in IDLE and in SETUP.
   - No rsp_valid_o pulse and no state change.
